alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 157 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a shared combinational integer ALU: arbitrates two requesters,
// keeps one operation in flight (MUL held for MUL_LAT cycles), and presents one response.
module alu_issue_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 4
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [31:0]      req0_pc_i,
  input  logic [31:0]      req0_instr_i,
  input  logic [31:0]      req0_a_i,
  input  logic [31:0]      req0_b_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [31:0]      req1_pc_i,
  input  logic [31:0]      req1_instr_i,
  input  logic [31:0]      req1_a_i,
  input  logic [31:0]      req1_b_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic [31:0]      alu_pc_o,
  output logic [31:0]      alu_instr_o,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  input  logic [31:0]      alu_result_i,
  input  logic             alu_illegal_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic             rsp_illegal_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_port_o,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high;
  // ready never waits on anything but this block's own state, rsp_ready_i and the valids.
  typedef enum logic [1:0] {IDLE, EXEC, MUL_WAIT, HOLD} state_t;

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

  state_t           state;
  logic [3:0]       mul_cnt;
  logic             last_grant;
  logic [TAG_W-1:0] op_tag;
  logic             op_port;

  logic             can_accept;
  logic             grant_port;
  logic             accept;
  logic [31:0]      sel_pc;
  logic [31:0]      sel_instr;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [TAG_W-1:0] sel_tag;

  function automatic logic is_mul(input logic [31:0] instr);
    return (instr[6:0] == 7'b0110011) && (instr[14:12] == 3'b000) &&
           (instr[31:25] == 7'b0000001);
  endfunction

  always_comb begin
    can_accept = (state == IDLE) || ((state == HOLD) && rsp_ready_i);
    // With both valid the port that did not win last time gets the slot.
    if (req0_valid_i && req1_valid_i) grant_port = ~last_grant;
    else                              grant_port = req1_valid_i;
    accept = rsn_i && can_accept && (req0_valid_i || req1_valid_i);
  end

  always_comb begin
    if (grant_port) begin
      sel_pc    = req1_pc_i;
      sel_instr = req1_instr_i;
      sel_a     = req1_a_i;
      sel_b     = req1_b_i;
      sel_tag   = req1_tag_i;
    end else begin
      sel_pc    = req0_pc_i;
      sel_instr = req0_instr_i;
      sel_a     = req0_a_i;
      sel_b     = req0_b_i;
      sel_tag   = req0_tag_i;
    end
  end

  assign req0_ready_o = accept && !grant_port;
  assign req1_ready_o = accept && grant_port;
  assign dbg_state_o  = state;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state         <= IDLE;
      mul_cnt       <= '0;
      last_grant    <= 1'b1;
      op_tag        <= '0;
      op_port       <= 1'b0;
      alu_pc_o      <= '0;
      alu_instr_o   <= '0;
      alu_a_o       <= '0;
      alu_b_o       <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= '0;
      rsp_illegal_o <= 1'b0;
      rsp_tag_o     <= '0;
      rsp_port_o    <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if ((state == HOLD) && rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
          // A new accept overrides the return to IDLE (back-to-back issue).
          if (accept) begin
            alu_pc_o    <= sel_pc;
            alu_instr_o <= sel_instr;
            alu_a_o     <= sel_a;
            alu_b_o     <= sel_b;
            op_tag      <= sel_tag;
            op_port     <= grant_port;
            last_grant  <= grant_port;
            if (is_mul(sel_instr)) begin
              state   <= MUL_WAIT;
              mul_cnt <= MUL_CNT_INIT;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          rsp_data_o    <= alu_result_i;
          rsp_illegal_o <= alu_illegal_i;
          rsp_tag_o     <= op_tag;
          rsp_port_o    <= op_port;
          rsp_valid_o   <= 1'b1;
          state         <= HOLD;
        end
        MUL_WAIT: begin
          if (mul_cnt == 4'd0) begin
            rsp_data_o    <= alu_result_i;
            rsp_illegal_o <= alu_illegal_i;
            rsp_tag_o     <= op_tag;
            rsp_port_o    <= op_port;
            rsp_valid_o   <= 1'b1;
            state         <= HOLD;
          end else begin
            mul_cnt <= mul_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios then random traffic, checked every cycle
// against a transaction-level model (expected-response queue plus per-op latency).
module tb_alu_issue_ctrl;
  localparam int MUL_LAT = 3;
  localparam int TAG_W   = 4;
  localparam int EXP_W   = 2 + TAG_W + 32;

  logic             clk_i = 1'b0;
  logic             rsn_i;
  logic             req0_valid_i, req0_ready_o;
  logic [31:0]      req0_pc_i, req0_instr_i, req0_a_i, req0_b_i;
  logic [TAG_W-1:0] req0_tag_i;
  logic             req1_valid_i, req1_ready_o;
  logic [31:0]      req1_pc_i, req1_instr_i, req1_a_i, req1_b_i;
  logic [TAG_W-1:0] req1_tag_i;
  logic [31:0]      alu_pc_o, alu_instr_o, alu_a_o, alu_b_o;
  logic [31:0]      alu_result_i;
  logic             alu_illegal_i;
  logic             rsp_valid_o, rsp_ready_i;
  logic [31:0]      rsp_data_o;
  logic             rsp_illegal_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             rsp_port_o;
  logic [1:0]       dbg_state_o;

  alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_pc_i(req0_pc_i),
    .req0_instr_i(req0_instr_i), .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_tag_i(req0_tag_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_pc_i(req1_pc_i),
    .req1_instr_i(req1_instr_i), .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_tag_i(req1_tag_i),
    .alu_pc_o(alu_pc_o), .alu_instr_o(alu_instr_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_result_i(alu_result_i), .alu_illegal_i(alu_illegal_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_illegal_o(rsp_illegal_o), .rsp_tag_o(rsp_tag_o), .rsp_port_o(rsp_port_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- ALU environment and reference ----------------
  function automatic logic is_mul_op(input logic [31:0] i);
    return (i[6:0] == 7'b0110011) && (i[14:12] == 3'b000) && (i[31:25] == 7'b0000001);
  endfunction

  // Returns {illegal, result}; only ADD, ADDI and MUL are implemented.
  function automatic logic [32:0] ref_alu(input logic [31:0] i, input logic [31:0] a,
                                          input logic [31:0] b);
    if (is_mul_op(i)) return {1'b0, a * b};
    if (i[6:0] == 7'b0110011 && i[14:12] == 3'b000 && i[31:25] == 7'b0000000)
      return {1'b0, a + b};
    if (i[6:0] == 7'b0010011 && i[14:12] == 3'b000)
      return {1'b0, a + {{20{i[31]}}, i[31:20]}};
    return {1'b1, 32'd0};
  endfunction

  assign {alu_illegal_i, alu_result_i} = ref_alu(alu_instr_o, alu_a_o, alu_b_o);

  function automatic logic [31:0] add_i();
    return {7'b0000000, 5'd3, 5'd1, 3'b000, 5'd2, 7'b0110011};
  endfunction
  function automatic logic [31:0] mul_i();
    return {7'b0000001, 5'd3, 5'd1, 3'b000, 5'd2, 7'b0110011};
  endfunction
  function automatic logic [31:0] addi_i(input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, 5'd2, 7'b0010011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 4))
      0: return add_i();
      1: return addi_i(r[11:0]);
      2: return mul_i();
      3: begin r[6:0] = 7'b0000000; return r; end
      default: return {7'b0000001, 5'd3, 5'd1, 3'b001, 5'd2, 7'b0110011};
    endcase
  endfunction

  // ---------------- scoreboard / model ----------------
  int               n_vec = 0;
  int               n_err = 0;
  int               n_dut_acc = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic             m_last, m_inflight, m_pending, m_in_reset, m_acc, m_grant;
  int               m_wait;
  logic [31:0]      m_pc, m_instr, m_a, m_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last = 1'b1; m_inflight = 1'b0; m_pending = 1'b0; m_acc = 1'b0; m_grant = 1'b0;
    m_wait = 0; m_pc = '0; m_instr = '0; m_a = '0; m_b = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req0_ready", 64'(req0_ready_o), 64'd0);
    check("rst_req1_ready", 64'(req1_ready_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rsp_data", 64'(rsp_data_o), 64'd0);
    check("rst_rsp_illegal", 64'(rsp_illegal_o), 64'd0);
    check("rst_rsp_tag", 64'(rsp_tag_o), 64'd0);
    check("rst_rsp_port", 64'(rsp_port_o), 64'd0);
    check("rst_alu_ops", {alu_a_o, alu_b_o}, 64'd0);
    check("rst_alu_pc_instr", {alu_pc_o, alu_instr_o}, 64'd0);
  endtask

  task automatic check_outputs();
    logic can;
    m_grant = (req0_valid_i && req1_valid_i) ? !m_last : req1_valid_i;
    can = !m_in_reset && !m_inflight && (!m_pending || rsp_ready_i) &&
          (req0_valid_i || req1_valid_i);
    check("req0_ready", 64'(req0_ready_o), 64'(can && !m_grant));
    check("req1_ready", 64'(req1_ready_o), 64'(can && m_grant));
    check("rsp_valid", 64'(rsp_valid_o), 64'(m_pending));
    if (m_pending && exp_q.size() > 0)
      check("rsp_fields", 64'({rsp_port_o, rsp_tag_o, rsp_illegal_o, rsp_data_o}), 64'(exp_q[0]));
    check("alu_ab", {alu_a_o, alu_b_o}, {m_a, m_b});
    check("alu_pc_instr", {alu_pc_o, alu_instr_o}, {m_pc, m_instr});
    if ((req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o)) n_dut_acc++;
    m_acc = can;
  endtask

  task automatic model_update();
    logic [TAG_W-1:0] tg;
    if (m_in_reset) return;
    if (m_pending && rsp_ready_i) begin
      void'(exp_q.pop_front());
      m_pending = 1'b0;
    end
    if (m_acc) begin
      if (m_grant) begin
        m_pc = req1_pc_i; m_instr = req1_instr_i; m_a = req1_a_i; m_b = req1_b_i; tg = req1_tag_i;
      end else begin
        m_pc = req0_pc_i; m_instr = req0_instr_i; m_a = req0_a_i; m_b = req0_b_i; tg = req0_tag_i;
      end
      exp_q.push_back({m_grant, tg, ref_alu(m_instr, m_a, m_b)});
      m_inflight = 1'b1;
      m_wait = is_mul_op(m_instr) ? MUL_LAT : 1;
      m_last = m_grant;
    end else if (m_inflight) begin
      m_wait--;
      if (m_wait == 0) begin
        m_inflight = 1'b0;
        m_pending  = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic [31:0] instr,
                       input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    if (p == 0) begin
      req0_valid_i = v; req0_instr_i = instr; req0_a_i = a; req0_b_i = b;
      req0_tag_i = tag; req0_pc_i = $urandom();
    end else begin
      req1_valid_i = v; req1_instr_i = instr; req1_a_i = a; req1_b_i = b;
      req1_tag_i = tag; req1_pc_i = $urandom();
    end
  endtask

  task automatic rand_drive(input int p, input logic v);
    drive(p, v, rand_instr(), $urandom(), $urandom(), TAG_W'($urandom()));
  endtask

  task automatic idle_cycles(input int n);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b1;
    repeat (n) cycle();
  endtask

  task automatic apply_reset();
    rsn_i = 1'b0;
    #1;
    model_reset();
    m_in_reset = 1'b1;
    check_reset_outputs();
  endtask

  // ---------------- directed then random sequence ----------------
  int base;

  initial begin
    rsn_i = 1'b1; rsp_ready_i = 1'b0;
    drive(0, 1'b0, '0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0, '0);
    model_reset();
    m_in_reset = 1'b0;
    #2;
    apply_reset();

    // Ready must stay low under reset even with both requesters valid.
    drive(0, 1'b1, add_i(), 32'd1, 32'd2, 4'd1);
    drive(1, 1'b1, add_i(), 32'd3, 32'd4, 4'd2);
    cycle(); cycle();
    rsn_i = 1'b1; m_in_reset = 1'b0;
    #1;
    check("first_grant_req0", 64'(req0_ready_o), 64'd1);
    check("first_grant_req1", 64'(req1_ready_o), 64'd0);
    cycle();
    idle_cycles(4);

    // ADDI on port 0.
    drive(0, 1'b1, addi_i(12'd3), 32'd5, 32'd0, 4'd2);
    rsp_ready_i = 1'b1;
    cycle();
    req0_valid_i = 1'b0;
    check("addi_not_yet_valid", 64'(rsp_valid_o), 64'd0);
    cycle();
    check("addi_valid", 64'(rsp_valid_o), 64'd1);
    check("addi_data", 64'(rsp_data_o), 64'd8);
    check("addi_tag_port_ill", 64'({rsp_tag_o, rsp_port_o, rsp_illegal_o}), 64'({4'd2, 1'b0, 1'b0}));
    cycle();
    idle_cycles(2);

    // MUL on port 1 with both ports pushing during the wait, then a long backpressure hold.
    rsp_ready_i = 1'b0;
    drive(1, 1'b1, mul_i(), 32'd6, 32'd7, 4'd5);
    cycle();
    drive(0, 1'b1, add_i(), 32'd10, 32'd20, 4'd1);
    repeat (3) cycle();
    check("mul_valid", 64'(rsp_valid_o), 64'd1);
    check("mul_data", 64'(rsp_data_o), 64'd42);
    check("mul_port_tag", 64'({rsp_port_o, rsp_tag_o}), 64'({1'b1, 4'd5}));
    repeat (5) cycle();
    check("hold_data_stable", 64'(rsp_data_o), 64'd42);
    rsp_ready_i = 1'b1;
    #1;
    check("b2b_grant_req0", 64'({req0_ready_o, req1_ready_o}), 64'b10);
    cycle();
    idle_cycles(4);

    // Both ports saturated with ADDs: alternating grants, one accept every two cycles.
    rsp_ready_i = 1'b1;
    base = n_dut_acc;
    repeat (8) begin
      drive(0, 1'b1, add_i(), $urandom(), $urandom(), TAG_W'($urandom()));
      drive(1, 1'b1, add_i(), $urandom(), $urandom(), TAG_W'($urandom()));
      cycle();
    end
    check("alternate_accepts", 64'(n_dut_acc - base), 64'd4);
    idle_cycles(4);

    // Illegal opcode still answers.
    drive(0, 1'b1, 32'hABCD_E000, 32'd9, 32'd4, 4'd7);
    cycle();
    req0_valid_i = 1'b0;
    cycle();
    check("illegal_flag", 64'(rsp_illegal_o), 64'd1);
    check("illegal_data_tag", 64'({rsp_data_o, rsp_tag_o}), 64'({32'd0, 4'd7}));
    cycle();
    idle_cycles(2);

    // Reset in the middle of a MUL wait: the MUL must vanish.
    drive(0, 1'b1, mul_i(), 32'd3, 32'd4, 4'd3);
    cycle();
    req0_valid_i = 1'b0;
    cycle();
    apply_reset();
    drive(0, 1'b1, add_i(), 32'd100, 32'd1, 4'd9);
    drive(1, 1'b1, add_i(), 32'd200, 32'd2, 4'd10);
    cycle();
    rsn_i = 1'b1; m_in_reset = 1'b0;
    #1;
    check("post_rst_grant", 64'({req0_ready_o, req1_ready_o}), 64'b10);
    cycle();
    idle_cycles(6);

    // Random traffic with random backpressure.
    repeat (400) begin
      rand_drive(0, $urandom_range(0, 9) < 6);
      rand_drive(1, $urandom_range(0, 9) < 6);
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle_cycles(20);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
